// File: rtl/lfsr_checker.sv
// PRBS checker: seeds a local N-bit LFSR from the stream, then free-runs and flags mismatches.
// err/locked/counters are registered one cycle after the sampled bit; there is no backpressure, din_valid qualifies each bit.
module lfsr_checker #(
   parameter int N        = 4,
   parameter int LOSS_THR = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din,
   input  logic        din_valid,
   input  logic        clr,
   output logic        locked,
   output logic        err,
   output logic [15:0] err_cnt,
   output logic [15:0] bit_cnt
);

   typedef enum logic {SEED, LOCK} state_t;

   localparam logic [7:0] TAPS = (N == 3) ? 8'h06 :
                                 (N == 4) ? 8'h0C :
                                 (N == 5) ? 8'h14 :
                                 (N == 6) ? 8'h30 :
                                 (N == 7) ? 8'h60 : 8'hB8;

   state_t        state_q;
   logic [N-1:0]  sr_q;
   logic [N-1:0]  sr_seed;
   logic [N-1:0]  sr_pred;
   logic [3:0]    seed_cnt_q;
   logic [3:0]    miss_q;
   logic          locked_q;
   logic          err_q;
   logic [15:0]   err_cnt_q;
   logic [15:0]   err_cnt_d;
   logic [15:0]   bit_cnt_q;
   logic [15:0]   bit_cnt_d;
   logic          p;
   logic          chk;
   logic          miss;
   logic          seed_last;

   assign p         = ^(sr_q & TAPS[N-1:0]);
   assign chk       = din_valid && (state_q == LOCK);
   assign miss      = chk && (din != p);
   assign sr_seed   = {sr_q[N-2:0], din};
   // once locked the register free-runs on its own prediction, so a bad bit never corrupts it
   assign sr_pred   = {sr_q[N-2:0], p};
   assign seed_last = (seed_cnt_q == 4'(N - 1));

   always_comb begin
      err_cnt_d = err_cnt_q;
      bit_cnt_d = bit_cnt_q;
      if (clr) begin
         err_cnt_d = 16'd0;
         bit_cnt_d = 16'd0;
      end else if (chk) begin
         if (bit_cnt_q != 16'hFFFF) bit_cnt_d = bit_cnt_q + 16'd1;
         if (miss && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= SEED;
         sr_q       <= '0;
         seed_cnt_q <= 4'd0;
         miss_q     <= 4'd0;
         locked_q   <= 1'b0;
         err_q      <= 1'b0;
         err_cnt_q  <= 16'd0;
         bit_cnt_q  <= 16'd0;
      end else begin
         err_q     <= miss;
         err_cnt_q <= err_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         case (state_q)
            SEED: begin
               if (din_valid) begin
                  sr_q <= sr_seed;
                  if (seed_last) begin
                     // an all-zero seed would lock the LFSR up, so start seeding over
                     seed_cnt_q <= 4'd0;
                     if (sr_seed != '0) begin
                        state_q  <= LOCK;
                        locked_q <= 1'b1;
                        miss_q   <= 4'd0;
                     end
                  end else begin
                     seed_cnt_q <= seed_cnt_q + 4'd1;
                  end
               end
            end
            LOCK: begin
               if (din_valid) begin
                  if (miss && (miss_q == 4'(LOSS_THR - 1))) begin
                     state_q    <= SEED;
                     locked_q   <= 1'b0;
                     sr_q       <= '0;
                     seed_cnt_q <= 4'd0;
                     miss_q     <= 4'd0;
                  end else begin
                     sr_q   <= sr_pred;
                     miss_q <= miss ? (miss_q + 4'd1) : 4'd0;
                  end
               end
            end
            default: state_q <= SEED;
         endcase
      end
   end

   assign locked  = locked_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;
   assign bit_cnt = bit_cnt_q;

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter N, default 4, meaning LFSR width; legal range 3..8.
REQ-002 SHALL have parameter LOSS_THR, default 4, meaning consecutive bit errors that drop lock; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning synchronous, active-high reset.
REQ-005 SHALL have port din, input, 1 bit, meaning the received serial bit (the generator's q[0] stream, one new bit per valid cycle).
REQ-006 SHALL have port din_valid, input, 1 bit, meaning din is sampled this cycle.
REQ-007 SHALL have port clr, input, 1 bit, meaning zero err_cnt and bit_cnt without affecting lock.
REQ-008 SHALL have port locked, output, 1 bit, meaning the local LFSR is synchronised to the stream.
REQ-009 SHALL have port err, output, 1 bit, meaning a one-cycle pulse: the last checked bit mismatched.
REQ-010 SHALL have port err_cnt, output, 16 bits, meaning the saturating count of mismatched bits while locked.
REQ-011 SHALL have port bit_cnt, output, 16 bits, meaning the saturating count of bits checked while locked.

Function
REQ-012 SHALL hold an N-bit register sr and shift sr[N-1:1] <= sr[N-2:0] on every accepted bit.
REQ-013 SHALL compute the predicted bit p from sr using fixed taps per N:
- N=3: sr[2]^sr[1]
- N=4: sr[3]^sr[2]
- N=5: sr[4]^sr[2]
- N=6: sr[5]^sr[4]
- N=7: sr[6]^sr[5]
- N=8: sr[7]^sr[5]^sr[4]^sr[3]
REQ-014 SHALL implement exactly two states, SEED and LOCK; reset state SEED.
REQ-015 In SEED, each din_valid SHALL shift din into sr[0] and increment a seed counter.
REQ-016 When the seed counter reaches N and the updated sr is non-zero, the state SHALL go to LOCK and locked SHALL read 1 on the following cycle.
REQ-017 When the seed counter reaches N and the updated sr is all-zero (lock-up state), the block SHALL clear the seed counter and stay in SEED.
REQ-018 In LOCK, each din_valid SHALL compare din with p, shift p (not din) into sr[0], and increment bit_cnt.
REQ-019 On a mismatch, err SHALL pulse high for exactly one cycle, registered, in the cycle after the sampled bit; err_cnt SHALL increment.
REQ-020 SHALL count consecutive mismatches; any match SHALL clear this count.
REQ-021 When the consecutive-mismatch count reaches LOSS_THR, the state SHALL return to SEED, locked SHALL drop on the next cycle, and the seed counter and sr SHALL clear.
REQ-022 err_cnt and bit_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-023 Neither counter SHALL change in SEED.
REQ-024 If din_valid=0, state, sr, and counters SHALL hold, and err SHALL be 0.
REQ-025 clr together with an accepted bit: clr SHALL win, both counters SHALL be 0 next cycle, and err SHALL still report that bit.
REQ-026 Latency: mismatch at bit k -> err high in cycle k+1.

Reset
REQ-027 rst=1 SHALL, on the next edge, force state SEED and set sr, the seed counter, the consecutive-mismatch count, locked, err, err_cnt, and bit_cnt to 0.
REQ-028 rst SHALL take priority over clr and din_valid, including mid-LOCK; after rst the block SHALL re-seed from scratch.

Verification
REQ-029 N=4, generator seeded 4'b0001, din_valid=1 continuously for 40 cycles -> locked=1 from cycle 5, err never 1, bit_cnt=36, err_cnt=0.
REQ-030 Same stream, one bit inverted at checked bit 10 -> err=1 for exactly one cycle, err_cnt=1, locked stays 1; no further errors (free-running prediction).
REQ-031 LOSS_THR=4, stream replaced by constant 0 while locked -> err on each bit, locked=0 after 4th mismatch, err_cnt=4; the N zeros then seeded keep the block in SEED.
REQ-032 N=8 with din_valid toggled 50% random -> locked once 8 bits are accepted, zero errors, bit_cnt equals accepted bits minus 8.
REQ-033 rst asserted mid-LOCK with err_cnt=3 -> all outputs 0 next cycle, re-lock after N valid bits.
REQ-034 err_cnt forced near saturation (65534 errors, or bounded via a force) -> err_cnt holds at 16'hFFFF; clr -> 0 next cycle.
